// File: rtl/camera_pattern_generator.sv
// camera_pattern_generator: synthetic RGGB pixel stream with fv/lv timing and selectable test patterns.
// All outputs are registered from the next-state values, so they line up with the state they describe.
module camera_pattern_generator #(
    parameter int X_SIZE    = 1280,
    parameter int Y_SIZE    = 720,
    parameter int H_BLANK   = 64,
    parameter int V_FRONT   = 16,
    parameter int V_BACK    = 16,
    parameter int FRAME_GAP = 32
) (
    input  logic       clock_pixel_in,
    input  logic       reset_pixel_in,
    input  logic       enable_in,
    input  logic       single_shot_in,
    input  logic [1:0] pattern_select_in,
    output logic       frame_valid_out,
    output logic       line_valid_out,
    output logic [9:0] pixel_data_out,
    output logic [7:0] frame_count_out,
    output logic       busy_out
);
    localparam logic [2:0] IDLE = 3'd0, FRONT = 3'd1, LINE = 3'd2, HBLANK = 3'd3, BACK = 3'd4, GAP = 3'd5;
    localparam logic [15:0] FRONT_END = 16'(V_FRONT - 1);
    localparam logic [15:0] HB_END    = 16'(H_BLANK - 1);
    localparam logic [15:0] BACK_END  = 16'(V_BACK - 1);
    localparam logic [15:0] GAP_END   = 16'(FRAME_GAP - 1);
    localparam logic [10:0] X_END     = 11'(X_SIZE - 1);
    localparam logic [9:0]  Y_END     = 10'(Y_SIZE - 1);

    logic [2:0]  state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [10:0] x, x_n;
    logic [9:0]  y, y_n, lfsr, lfsr_n, pix;
    logic [1:0]  pat, pat_n;
    logic        start, frame_done;

    // A busy pulse is dropped; only a held enable chains straight from GAP into the next frame.
    assign start = (state == IDLE && (enable_in || single_shot_in)) ||
                   (state == GAP && cnt == GAP_END && enable_in);
    assign frame_done = state == BACK && cnt == BACK_END;

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 16'd1;
        x_n     = x;
        y_n     = y;
        pat_n   = pat;
        lfsr_n  = lfsr;
        case (state)
            FRONT: if (cnt == FRONT_END) begin
                state_n = LINE;
                cnt_n   = '0;
            end
            LINE: begin
                lfsr_n = {lfsr[8:0], lfsr[9] ^ lfsr[6]};
                if (x == X_END) begin
                    state_n = (y == Y_END) ? BACK : HBLANK;
                    cnt_n   = '0;
                end else
                    x_n = x + 11'd1;
            end
            HBLANK: if (cnt == HB_END) begin
                state_n = LINE;
                x_n     = '0;
                y_n     = y + 10'd1;
            end
            BACK: if (frame_done) begin
                state_n = GAP;
                cnt_n   = '0;
            end
            GAP: if (cnt == GAP_END) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (start) begin
            state_n = FRONT;
            cnt_n   = '0;
            x_n     = '0;
            y_n     = '0;
            lfsr_n  = 10'h001;
            pat_n   = pattern_select_in;
        end
    end

    assign pix = pat_n == 2'd0 ? x_n[9:0] :
                 pat_n == 2'd1 ? (x_n[0] == y_n[0] ? (y_n[0] ? 10'h000 : 10'h3FF) : 10'h200) :
                 pat_n == 2'd2 ? {10{x_n[4] ^ y_n[4]}} : lfsr_n;

    always_ff @(posedge clock_pixel_in) begin
        if (reset_pixel_in) begin
            state           <= IDLE;
            cnt             <= '0;
            x               <= '0;
            y               <= '0;
            pat             <= '0;
            lfsr            <= 10'h001;
            frame_valid_out <= 1'b0;
            line_valid_out  <= 1'b0;
            pixel_data_out  <= '0;
            frame_count_out <= '0;
            busy_out        <= 1'b0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            x               <= x_n;
            y               <= y_n;
            pat             <= pat_n;
            lfsr            <= lfsr_n;
            frame_valid_out <= state_n inside {FRONT, LINE, HBLANK, BACK};
            line_valid_out  <= state_n == LINE;
            pixel_data_out  <= state_n == LINE ? pix : 10'h000;
            busy_out        <= state_n != IDLE;
            if (frame_done) frame_count_out <= frame_count_out + 8'd1;
        end
    end
endmodule
